// File: rtl/alu_op_sequencer.sv
// Registered ALU funct decoder with valid/ready handshake and iterative mul/div sequencing.
// Latency: 1 cycle for single-cycle ops; ITERS+1 cycles from accept to hilo_we for mul/div.
// Backpressure: in_ready drops while a mul/div runs (ITER/DONE) and during rst.
// Optional feature: define ALU_SEQ_ILLEGAL_TRAP_EN to trap ALUOp==11 as an illegal NOP.
module alu_op_sequencer #(
  parameter int FUNCT_W = 6,
  parameter int ITERS   = 32,
  localparam int CNT_W  = $clog2(ITERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] funct_ctrl,
  output logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  output logic               busy,
  output logic               iter_en,
  output logic [CNT_W-1:0]   iter_cnt,
  output logic               iter_last,
  output logic               hilo_we,
  output logic               illegal
);

  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic [FUNCT_W-1:0] funct_q, funct_d, code;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic               accept, is_multi, cnt_last;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic               is_illegal, ill_q, ill_d;
`endif

  assign in_ready = (state_q == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt_q == CNT_MAX);

  always_comb begin
    code     = F_ADD;
    is_multi = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    is_illegal = 1'b0;
`endif
    case (ALUOp)
      2'b00: code = F_ADD;
      2'b01: code = F_SUB;
      2'b10: begin
        code     = funct_ctrl;
        is_multi = (funct_ctrl == F_MULT) || (funct_ctrl == F_MULTU) ||
                   (funct_ctrl == F_DIV)  || (funct_ctrl == F_DIVU);
      end
      default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        code       = '0;
        is_illegal = 1'b1;
`else
        code = F_ADD;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    funct_d = funct_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ill_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct_d = code;
          cnt_d   = '0;
          if (is_multi) begin
            state_d = ITER;
          end else begin
            ov_d = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            ill_d = is_illegal;
`endif
          end
        end
      end
      // Counter saturates at the last step; DONE clears it on exit.
      ITER: begin
        if (cnt_last) state_d = DONE;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      funct_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else     ill_q <= ill_d;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  // All status outputs are decoded from registered state only.
  assign funct     = funct_q;
  assign iter_cnt  = cnt_q;
  assign busy      = (state_q != IDLE);
  assign iter_en   = (state_q == ITER);
  assign iter_last = (state_q == ITER) & cnt_last;
  assign hilo_we   = (state_q == DONE);
  assign out_valid = ov_q | (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: cycle-scheduled expectation model plus directed literal checks.
module tb_alu_op_sequencer;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;
  localparam int NC    = 1024;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct_ctrl, funct;
  logic             out_valid, busy, iter_en, iter_last, hilo_we, illegal;
  logic [CNT_W-1:0] iter_cnt;

  alu_op_sequencer #(.FUNCT_W(6), .ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(alu_op), .funct_ctrl(funct_ctrl), .funct(funct),
    .out_valid(out_valid), .busy(busy), .iter_en(iter_en), .iter_cnt(iter_cnt),
    .iter_last(iter_last), .hilo_we(hilo_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_cyc = 0;
  int hilo_cnt = 0;
  logic [5:0] m_funct = 6'd0;

  // Expected per-cycle outputs, indexed by absolute cycle number.
  bit             e_ov[NC], e_busy[NC], e_iten[NC], e_last[NC], e_hilo[NC], e_ill[NC];
  bit [CNT_W-1:0] e_cnt[NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fc,
                                     output logic [5:0] code, output bit multi, output bit ill);
    multi = 1'b0;
    ill   = 1'b0;
    case (op)
      2'd0: code = 6'd32;
      2'd1: code = 6'd34;
      2'd2: begin
        code  = fc;
        multi = (fc >= 6'd24) && (fc <= 6'd27);
      end
      default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        code = 6'd0;
        ill  = 1'b1;
`else
        code = 6'd32;
`endif
      end
    endcase
  endfunction

  // Model: on each edge, schedule the future output pattern for whatever is accepted.
  always @(posedge clk) begin
    int c;
    logic [5:0] code;
    bit multi, ill;
    c = cyc;
    if (rst) begin
      for (int k = c + 1; k <= c + ITERS + 2; k++) begin
        e_ov[k] = 0; e_busy[k] = 0; e_iten[k] = 0; e_last[k] = 0;
        e_hilo[k] = 0; e_ill[k] = 0; e_cnt[k] = '0;
      end
      m_funct  = 6'd0;
      free_cyc = c + 1;
    end else if (in_valid && c >= free_cyc) begin
      ref_decode(alu_op, funct_ctrl, code, multi, ill);
      m_funct = code;
      if (multi) begin
        for (int i = 0; i < ITERS; i++) begin
          e_busy[c+1+i] = 1;
          e_iten[c+1+i] = 1;
          e_cnt[c+1+i]  = CNT_W'(i);
          e_last[c+1+i] = (i == ITERS - 1);
        end
        e_busy[c+1+ITERS] = 1;
        e_ov[c+1+ITERS]   = 1;
        e_hilo[c+1+ITERS] = 1;
        e_cnt[c+1+ITERS]  = CNT_W'(ITERS - 1);
        free_cyc = c + 2 + ITERS;
      end else begin
        e_ov[c+1]  = 1;
        e_ill[c+1] = ill;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NC) begin
      chk("in_ready",  in_ready,  32'(!rst && cyc >= free_cyc));
      chk("funct",     funct,     32'(m_funct));
      chk("out_valid", out_valid, 32'(e_ov[cyc]));
      chk("busy",      busy,      32'(e_busy[cyc]));
      chk("iter_en",   iter_en,   32'(e_iten[cyc]));
      chk("iter_cnt",  iter_cnt,  32'(e_cnt[cyc]));
      chk("iter_last", iter_last, 32'(e_last[cyc]));
      chk("hilo_we",   hilo_we,   32'(e_hilo[cyc]));
      chk("illegal",   illegal,   32'(e_ill[cyc]));
      if (hilo_we) hilo_cnt++;
    end
  end

  task automatic drive(input logic [1:0] op, input logic [5:0] fc);
    in_valid   = 1'b1;
    alu_op     = op;
    funct_ctrl = fc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 2'd0; funct_ctrl = 6'd0;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  0);
    @(posedge clk); #1;
    chk("rst_funct", funct, 0);
    chk("rst_busy",  busy,  0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Back-to-back R-type single-cycle ops.
    drive(2'd2, 6'b100101); chk("b2b_f0", funct, 6'b100101); chk("b2b_v0", out_valid, 1);
    drive(2'd2, 6'b001101); chk("b2b_f1", funct, 6'b001101); chk("b2b_v1", out_valid, 1);
    drive(2'd2, 6'b000010); chk("b2b_f2", funct, 6'b000010); chk("b2b_v2", out_valid, 1);
    idle_cycles(1);
    chk("hold_funct", funct, 6'b000010);
    chk("hold_valid", out_valid, 0);

    drive(2'd0, 6'($urandom)); chk("add_code", funct, 6'b100000);
    drive(2'd1, 6'($urandom)); chk("sub_code", funct, 6'b100010);
    idle_cycles(2);

    // MULT with in_valid held high through the iterations.
    drive(2'd2, 6'b011000);
    alu_op = 2'd0;
    for (int i = 0; i < ITERS; i++) begin
      chk("mult_iter_en",   iter_en,   1);
      chk("mult_iter_cnt",  iter_cnt,  32'(i));
      chk("mult_iter_last", iter_last, 32'(i == ITERS - 1));
      chk("mult_ready",     in_ready,  0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mult_hilo", hilo_we, 1);
    chk("mult_ov",   out_valid, 1);
    chk("mult_funct", funct, 6'b011000);
    @(posedge clk); #1;
    chk("mult_after_hilo",  hilo_we,  0);
    chk("mult_after_ready", in_ready, 1);

    // DIVU aborted by reset at step 10.
    drive(2'd2, 6'b011011);
    repeat (10) @(posedge clk);
    #1;
    chk("divu_cnt10", iter_cnt, 10);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",  busy,    0);
    chk("abort_iten",  iter_en, 0);
    chk("abort_funct", funct,   0);
    rst = 1'b0;
    idle_cycles(40);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    drive(2'd3, 6'b010101);
    chk("op11_illegal", illegal, 1);
    chk("op11_funct",   funct,   6'b000000);
`else
    drive(2'd3, 6'b010101);
    chk("op11_illegal", illegal, 0);
    chk("op11_funct",   funct,   6'b100000);
`endif
    chk("op11_valid", out_valid, 1);

    // Single-cycle op immediately followed by MULTU.
    drive(2'd1, 6'd0);
    drive(2'd2, 6'b011001);
    idle_cycles(ITERS + 4);
    chk("hilo_total", hilo_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
